// File: rtl/tpu_instr_recv_if.sv
// tpu_instr_recv_if
// Bundles the MPU dispatch stream, the sequencer instruction/end handshake
// and the commit request of tpu_instr_recv into one interface.
//   slave  : the receiver side (tpu_instr_recv)
//   master : the environment driving the dispatch and sequencer inputs
interface tpu_instr_recv_if #(
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_ISSUE = 4,
  parameter int DEPTH       = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                   I_Req;
  logic [WIDTH_INSTR-1:0] I_Instr;
  logic [WIDTH_ISSUE-1:0] I_IssueNo;
  logic                   O_Busy;
  logic                   O_Req_Instr;
  logic [WIDTH_INSTR-1:0] O_Instr;
  logic                   I_Ack_Instr;
  logic                   I_End_Exe;
  logic                   O_Req_Commit;
  logic [WIDTH_ISSUE-1:0] O_CommitNo;
  logic [CW-1:0]          O_Count;
  logic                   O_Error;

  modport slave (
    input  I_Req, I_Instr, I_IssueNo, I_Ack_Instr, I_End_Exe,
    output O_Busy, O_Req_Instr, O_Instr, O_Req_Commit, O_CommitNo,
           O_Count, O_Error
  );

  modport master (
    output I_Req, I_Instr, I_IssueNo, I_Ack_Instr, I_End_Exe,
    input  O_Busy, O_Req_Instr, O_Instr, O_Req_Commit, O_CommitNo,
           O_Count, O_Error
  );
endinterface

// File: rtl/tpu_instr_recv.sv
// tpu_instr_recv
// Receives one thread of instructions from the MPU dispatch stream into a
// FIFO, hands them to the sequencer, waits for the end of execution and
// then issues a single-cycle commit request carrying the thread issue number.
// Ports:
//   clock : single rising-edge clock
//   reset : synchronous active-low reset
//   bus   : tpu_instr_recv_if.slave (dispatch in, FIFO out, end/commit, status)
module tpu_instr_recv #(
  parameter int WIDTH_INSTR = 32,
  parameter int WIDTH_ISSUE = 4,
  parameter int DEPTH       = 16
) (
  input  logic              clock,
  input  logic              reset,
  tpu_instr_recv_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    EXEC   = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [WIDTH_INSTR-1:0] mem_r [DEPTH];
  logic [AW-1:0]          wr_ptr_r;
  logic [AW-1:0]          rd_ptr_r;
  logic [CW-1:0]          count_r;
  logic [WIDTH_ISSUE-1:0] issue_r;
  logic [WIDTH_ISSUE-1:0] commit_no_r;
  logic                   end_seen_r;
  logic                   busy_r;
  logic                   req_commit_r;
  logic                   error_r;

  logic                   accepting_s;
  logic                   full_s;
  logic                   pop_s;
  logic                   wr_en_s;
  logic                   err_set_s;
  logic                   empty_after_pop_s;
  logic                   latch_issue_s;

  // FIFO control and error detection.
  always_comb begin
    accepting_s       = (state_r == IDLE) || (state_r == RECV);
    full_s            = (count_r == CW'(DEPTH));
    pop_s             = bus.I_Ack_Instr && (count_r != {CW{1'b0}});
    // A full FIFO still takes a word when the head leaves in the same cycle.
    wr_en_s           = bus.I_Req && accepting_s && (!full_s || pop_s);
    err_set_s         = bus.I_Req && !wr_en_s;
    // No writes are accepted in EXEC, so only the pop matters here.
    empty_after_pop_s = ((count_r - CW'(pop_s)) == {CW{1'b0}});
  end

  // Next-state decision.
  always_comb begin
    state_next_s  = state_r;
    latch_issue_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.I_Req) begin
          state_next_s  = RECV;
          latch_issue_s = 1'b1;
        end else begin
          state_next_s  = IDLE;
        end
      end
      RECV: begin
        if (bus.I_Req) begin
          state_next_s = RECV;
        end else begin
          state_next_s = EXEC;
        end
      end
      EXEC: begin
        if ((end_seen_r || bus.I_End_Exe) && empty_after_pop_s) begin
          state_next_s = COMMIT;
        end else begin
          state_next_s = EXEC;
        end
      end
      COMMIT:  state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, pointers, thread bookkeeping and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r      <= IDLE;
      wr_ptr_r     <= {AW{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      count_r      <= {CW{1'b0}};
      issue_r      <= {WIDTH_ISSUE{1'b0}};
      commit_no_r  <= {WIDTH_ISSUE{1'b0}};
      end_seen_r   <= 1'b0;
      busy_r       <= 1'b0;
      req_commit_r <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      wr_ptr_r <= wr_en_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
      rd_ptr_r <= pop_s   ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
      count_r  <= count_r + CW'(wr_en_s) - CW'(pop_s);
      issue_r  <= latch_issue_s ? bus.I_IssueNo : issue_r;
      if (state_next_s == IDLE) begin
        end_seen_r <= 1'b0;
      end else if (bus.I_End_Exe && ((state_r == RECV) || (state_r == EXEC))) begin
        end_seen_r <= 1'b1;
      end else begin
        end_seen_r <= end_seen_r;
      end
      // Outputs are registered from the next state so they line up with state_r.
      busy_r       <= (state_next_s != IDLE);
      req_commit_r <= (state_next_s == COMMIT);
      commit_no_r  <= (state_next_s == COMMIT) ? issue_r : {WIDTH_ISSUE{1'b0}};
      error_r      <= error_r || err_set_s;
    end
  end

  // FIFO storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= bus.I_Instr;
    end
  end

  assign bus.O_Busy       = busy_r;
  assign bus.O_Req_Instr  = (count_r != {CW{1'b0}});
  assign bus.O_Instr      = mem_r[rd_ptr_r];
  assign bus.O_Count      = count_r;
  assign bus.O_Req_Commit = req_commit_r;
  assign bus.O_CommitNo   = commit_no_r;
  assign bus.O_Error      = error_r;
endmodule
